// File: rtl/id_trace_pkg.sv
// Shared types for the ID-stage register-writeback trace buffer: the trace entry
// layout and the helper that orders accepted write ports into buffer slots.
package id_trace_pkg;

  localparam int PKG_DATA_W = 32;
  localparam int PKG_REG_AW = 5;
  localparam int PKG_NUM_WR = 2;
  localparam int PKG_TS_W   = 16;
  localparam int PKG_PORT_W = (PKG_NUM_WR > 1) ? $clog2(PKG_NUM_WR) : 1;

  typedef struct packed {
    logic [PKG_TS_W-1:0]   ts;
    logic [PKG_PORT_W-1:0] port;
    logic [PKG_REG_AW-1:0] reg_idx;
    logic [PKG_DATA_W-1:0] data;
  } trace_entry_t;

  // Slot of port p within this cycle's pushes: number of accepted ports below p.
  function automatic int acc_rank(input logic [3:0] acc, input int p);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      if ((i < p) && acc[i]) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/id_regtrace_if.sv
// Drain side of the trace buffer: FWFT head entry with a valid/ready handshake.
interface id_regtrace_if;
  import id_trace_pkg::*;

  logic         o_valid;
  logic         i_ready;
  trace_entry_t o_entry;

  modport master (output o_valid, output o_entry, input  i_ready);
  modport slave  (input  o_valid, input  o_entry, output i_ready);

endinterface

// File: rtl/id_trace_fifo.sv
// Circular trace buffer accepting up to NUM_WR pushes and one pop per cycle, with
// drop-newest or evict-oldest overflow; reports entries lost each cycle.
module id_trace_fifo
  import id_trace_pkg::*;
#(
  parameter int NUM_WR    = 2,
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 0,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1,
  localparam int PN_W = $clog2(NUM_WR + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  trace_entry_t      push_ent [NUM_WR],
  input  logic [PN_W-1:0]   push_n,
  input  logic              pop_rdy,
  output logic              head_vld,
  output trace_entry_t      head,
  output logic [CW-1:0]     count,
  output logic [PN_W-1:0]   drop_n
);

  trace_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_p0, wr_p0, rd_nxt, wr_nxt;
  logic [CW-1:0] cnt_p0, cnt_nxt;
  logic [CW-1:0] free, pn, n_wr, evict, loss;
  logic          pop;

  assign head_vld = (cnt_p0 != '0);
  assign head     = head_vld ? mem[rd_p0] : '0;
  assign count    = cnt_p0;
  assign pop      = head_vld && pop_rdy;
  assign drop_n   = PN_W'(loss);

  always_comb begin
    free    = CW'(DEPTH) - cnt_p0 + CW'(pop);
    pn      = CW'(push_n);
    n_wr    = '0;
    evict   = '0;
    loss    = '0;
    rd_nxt  = '0;
    wr_nxt  = '0;
    cnt_nxt = '0;
    if (!i_clear) begin
      if (OVERWRITE != 0) begin
        n_wr = pn;
        if (pn > free) evict = pn - free;
        loss = evict;
      end else begin
        n_wr = (pn > free) ? free : pn;
        loss = pn - n_wr;
      end
      rd_nxt  = rd_p0 + AW'(pop) + AW'(evict);
      wr_nxt  = wr_p0 + AW'(n_wr);
      cnt_nxt = cnt_p0 - CW'(pop) - evict + n_wr;
    end
  end

  // ---- stage 0 -> 1: pointer/count update (control only) ----
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rd_p0  <= '0;
      wr_p0  <= '0;
      cnt_p0 <= '0;
    end else begin
      rd_p0  <= rd_nxt;
      wr_p0  <= wr_nxt;
      cnt_p0 <= cnt_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_WR; i++) begin
      if (CW'(i) < n_wr) mem[wr_p0 + AW'(i)] <= push_ent[i];
    end
  end

endmodule

// File: rtl/id_regtrace.sv
// ID-stage register-writeback tracer: filters snooped writes, timestamps them,
// buffers them for a valid/ready consumer and counts entries lost to overflow.
module id_regtrace
  import id_trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int NUM_WR    = 2,
  parameter int DEPTH     = 16,
  parameter int TS_W      = 16,
  parameter int DROP_W    = 8,
  parameter int OVERWRITE = 0,
  localparam int PN_W = $clog2(NUM_WR + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_enable,
  input  logic                           i_clear,
  input  logic [2**REG_AW-1:0]           i_regMask,
  input  logic [NUM_WR-1:0]              i_wrSig,
  input  logic [NUM_WR-1:0][REG_AW-1:0]  i_wrReg,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  i_wrData,
  id_regtrace_if.master                  trace,
  output logic [$clog2(DEPTH):0]         o_count,
  output logic [DROP_W-1:0]              o_dropCnt,
  output logic                           o_overflow
);

  if (DATA_W != PKG_DATA_W || REG_AW != PKG_REG_AW || NUM_WR != PKG_NUM_WR ||
      TS_W != PKG_TS_W) begin : g_pkg_mismatch
    $error("id_regtrace: parameters disagree with id_trace_pkg entry layout");
  end
  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 * NUM_WR || NUM_WR < 1 || NUM_WR > 4)
  begin : g_depth_bad
    $error("id_regtrace: DEPTH must be a power of 2 >= 2*NUM_WR, NUM_WR in 1..4");
  end

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [PN_W-1:0]   b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + (DROP_W + 1)'(b);
    return s[DROP_W] ? '1 : s[DROP_W-1:0];
  endfunction

  logic [TS_W-1:0]   ts_p0;
  logic [NUM_WR-1:0] acc;
  logic [PN_W-1:0]   push_n, drop_n;
  trace_entry_t      push_ent [NUM_WR];
  logic [DROP_W-1:0] drop_cnt_p0;
  logic              ovf_p0;

  always_comb begin
    for (int p = 0; p < NUM_WR; p++) begin
      acc[p] = i_enable && i_wrSig[p] && (i_wrReg[p] != '0) && i_regMask[i_wrReg[p]];
    end
  end

  // Accepted ports pack into consecutive slots in ascending port order.
  always_comb begin
    int r;
    for (int s = 0; s < NUM_WR; s++) push_ent[s] = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      r = acc_rank(4'(acc), p);
      if (acc[p]) begin
        push_ent[r].ts      = ts_p0;
        push_ent[r].port    = PKG_PORT_W'(p);
        push_ent[r].reg_idx = i_wrReg[p];
        push_ent[r].data    = i_wrData[p];
      end
    end
    push_n = PN_W'($countones(acc));
  end

  id_trace_fifo #(
    .NUM_WR    (NUM_WR),
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (i_clear),
    .push_ent  (push_ent),
    .push_n    (push_n),
    .pop_rdy   (trace.i_ready),
    .head_vld  (trace.o_valid),
    .head      (trace.o_entry),
    .count     (o_count),
    .drop_n    (drop_n)
  );

  // ---- stage 0 -> 1: timestamp and loss accounting ----
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) ts_p0 <= '0;
    else            ts_p0 <= ts_p0 + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_clear) begin
      drop_cnt_p0 <= '0;
      ovf_p0      <= 1'b0;
    end else if (drop_n != '0) begin
      drop_cnt_p0 <= sat_add(drop_cnt_p0, drop_n);
      ovf_p0      <= 1'b1;
    end
  end

  assign o_dropCnt  = drop_cnt_p0;
  assign o_overflow = ovf_p0;

endmodule

// File: tb/tb_id_regtrace.sv
// Directed bench for id_regtrace: one drop-mode and one overwrite-mode instance
// driven by the same write stream.
module tb_id_regtrace;
  import id_trace_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   en = 1'b1;
  logic                   clr = 1'b0;
  logic [31:0]            mask = '1;
  logic [1:0]             wr_sig = '0;
  logic [1:0][4:0]        wr_reg = '0;
  logic [1:0][31:0]       wr_data = '0;
  logic [4:0]             cnt_a, cnt_b;
  logic [7:0]             drop_a, drop_b;
  logic                   ovf_a, ovf_b;
  logic [15:0]            ts_m = '0;
  logic [15:0]            ts0, tsx;
  int                     checks = 0;
  int                     failures = 0;

  id_regtrace_if ifa ();
  id_regtrace_if ifb ();

  always #5 clk = ~clk;

  id_regtrace #(.OVERWRITE(0)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_clear(clr), .i_regMask(mask),
    .i_wrSig(wr_sig), .i_wrReg(wr_reg), .i_wrData(wr_data), .trace(ifa),
    .o_count(cnt_a), .o_dropCnt(drop_a), .o_overflow(ovf_a));

  id_regtrace #(.OVERWRITE(1)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_clear(clr), .i_regMask(mask),
    .i_wrSig(wr_sig), .i_wrReg(wr_reg), .i_wrData(wr_data), .trace(ifb),
    .o_count(cnt_b), .o_dropCnt(drop_b), .o_overflow(ovf_b));

  function automatic trace_entry_t mk(input logic [15:0] ts, input logic p,
                                      input logic [4:0] r, input logic [31:0] d);
    trace_entry_t e;
    e.ts = ts; e.port = p; e.reg_idx = r; e.data = d;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ent(input string tag, input trace_entry_t obs, input trace_entry_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    ts_m = rst_n ? ts_m + 16'd1 : 16'd0;
    #1;
  endtask

  task automatic drv(input logic [1:0] sig, input logic [4:0] r0, input logic [31:0] d0,
                     input logic [4:0] r1, input logic [31:0] d1);
    wr_sig = sig;
    wr_reg[0] = r0; wr_data[0] = d0;
    wr_reg[1] = r1; wr_data[1] = d1;
  endtask

  initial begin
    ifa.i_ready = 1'b0;
    ifb.i_ready = 1'b0;
    step(); step();
    chk("rst_valid", 32'(ifa.o_valid), 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_drop", 32'(drop_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk_ent("rst_entry", ifa.o_entry, '0);

    rst_n = 1'b1;
    step(); step(); step();
    // push at ts=3 with ready already high: no bypass, entry appears next cycle
    drv(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
    ifa.i_ready = 1'b1;
    step();
    drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    chk("first_valid", 32'(ifa.o_valid), 32'd1);
    chk_ent("first_entry", ifa.o_entry, mk(16'd3, 1'b0, 5'd5, 32'hDEADBEEF));
    chk("first_count", 32'(cnt_a), 32'd1);
    step();
    chk("first_popped", 32'(cnt_a), 32'd0);
    ifa.i_ready = 1'b0;

    mask = 32'hFFFF_FF7F;
    drv(2'b11, 5'd0, 32'h1234, 5'd7, 32'h5678);
    step();
    chk("filter_count", 32'(cnt_a), 32'd0);
    chk("filter_drop", 32'(drop_a), 32'd0);
    mask = '1;
    en = 1'b0;
    drv(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
    step();
    chk("disabled_count", 32'(cnt_a), 32'd0);
    en = 1'b1;

    drv(2'b11, 5'd1, 32'h11, 5'd2, 32'h22);
    ts0 = ts_m;
    step();
    drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    chk("dual_count", 32'(cnt_a), 32'd2);
    chk_ent("dual_head0", ifa.o_entry, mk(ts0, 1'b0, 5'd1, 32'h11));
    ifa.i_ready = 1'b1;
    step();
    chk_ent("dual_head1", ifa.o_entry, mk(ts0, 1'b1, 5'd2, 32'h22));
    step();
    chk("dual_empty_cnt", 32'(cnt_a), 32'd0);
    chk("dual_empty_vld", 32'(ifa.o_valid), 32'd0);
    ifa.i_ready = 1'b0;
    ifb.i_ready = 1'b0;

    // clear B (it also captured the earlier pushes) so both start the fill empty
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("b_cleared", 32'(cnt_b), 32'd0);

    ts0 = ts_m;
    for (int k = 0; k < 9; k++) begin
      drv(2'b11, 5'd1, 32'h100 + 32'(2 * k), 5'd2, 32'h101 + 32'(2 * k));
      step();
    end
    chk("full_cnt_a", 32'(cnt_a), 32'd16);
    chk("full_drop_a", 32'(drop_a), 32'd2);
    chk("full_ovf_a", 32'(ovf_a), 32'd1);
    chk_ent("full_head_a", ifa.o_entry, mk(ts0, 1'b0, 5'd1, 32'h100));
    chk("full_cnt_b", 32'(cnt_b), 32'd16);
    chk("full_drop_b", 32'(drop_b), 32'd2);
    chk("full_ovf_b", 32'(ovf_b), 32'd1);
    chk_ent("full_head_b", ifb.o_entry, mk(ts0 + 16'd1, 1'b0, 5'd1, 32'h102));

    // full + pop + two pushes: one slot frees, so one entry is lost
    ifa.i_ready = 1'b1;
    ifb.i_ready = 1'b1;
    drv(2'b11, 5'd3, 32'h300, 5'd4, 32'h301);
    step();
    ifa.i_ready = 1'b0;
    ifb.i_ready = 1'b0;
    chk("fullpop_cnt_a", 32'(cnt_a), 32'd16);
    chk("fullpop_drop_a", 32'(drop_a), 32'd3);
    chk_ent("fullpop_head_a", ifa.o_entry, mk(ts0, 1'b1, 5'd2, 32'h101));
    chk("fullpop_cnt_b", 32'(cnt_b), 32'd16);
    chk("fullpop_drop_b", 32'(drop_b), 32'd3);
    chk_ent("fullpop_head_b", ifb.o_entry, mk(ts0 + 16'd2, 1'b0, 5'd1, 32'h104));

    clr = 1'b1;
    ifa.i_ready = 1'b1;
    drv(2'b11, 5'd5, 32'h500, 5'd6, 32'h501);
    step();
    clr = 1'b0;
    ifa.i_ready = 1'b0;
    chk("clr_cnt_a", 32'(cnt_a), 32'd0);
    chk("clr_vld_a", 32'(ifa.o_valid), 32'd0);
    chk("clr_drop_a", 32'(drop_a), 32'd0);
    chk("clr_ovf_a", 32'(ovf_a), 32'd0);
    chk("clr_cnt_b", 32'(cnt_b), 32'd0);
    chk("clr_drop_b", 32'(drop_b), 32'd0);
    drv(2'b10, 5'd0, 32'd0, 5'd3, 32'h33);
    tsx = ts_m;
    step();
    chk_ent("clr_ts_runs", ifa.o_entry, mk(tsx, 1'b1, 5'd3, 32'h33));

    for (int k = 0; k < 140; k++) begin
      drv(2'b11, 5'd8, 32'(k), 5'd9, 32'(k));
      step();
    end
    chk("sat_drop_a", 32'(drop_a), 32'd255);
    chk("sat_drop_b", 32'(drop_b), 32'd255);
    chk("sat_cnt_b", 32'(cnt_b), 32'd16);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_cnt", 32'(cnt_a), 32'd0);
    chk("mid_rst_vld", 32'(ifa.o_valid), 32'd0);
    chk("mid_rst_drop", 32'(drop_a), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_a), 32'd0);
    chk_ent("mid_rst_entry", ifa.o_entry, '0);
    chk("mid_rst_cnt_b", 32'(cnt_b), 32'd0);
    drv(2'b01, 5'd4, 32'h44, 5'd0, 32'd0);
    step();
    drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    chk_ent("mid_rst_ts0", ifa.o_entry, mk(16'd0, 1'b0, 5'd4, 32'h44));
    chk("mid_rst_push_cnt", 32'(cnt_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_regtrace.md
# id_regtrace

Synthesizable, parametrised register-writeback trace buffer for the ID stage. Snoops up to NUM_WR register-file write ports each cycle, filters by register, timestamps each accepted write, and holds entries in a circular buffer drained over a valid/ready interface. Runs in silicon or FPGA without file I/O. Overflow is handled by a drop or an overwrite policy, and dropped entries are counted.

## Interface
- DATA_W, 32, register data width
- REG_AW, 5, register address width (2**REG_AW registers)
- NUM_WR, 2, number of snooped write ports (1..4)
- DEPTH, 16, buffer entries; power of 2, at least 2*NUM_WR
- TS_W, 16, timestamp counter width
- DROP_W, 8, dropped-entry counter width
- OVERWRITE, 0, overflow policy: 0 = drop newest, 1 = evict oldest

- i_clk  in  1  clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_enable  in  1  capture enable; timestamp still counts when low
- i_clear  in  1  synchronous flush of buffer and drop counter
- i_regMask  in  2**REG_AW  bit r=1 traces register r
- i_wrSig  in  NUM_WR  per-port write strobe
- i_wrReg  in  NUM_WR x REG_AW  per-port destination register
- i_wrData  in  NUM_WR x DATA_W  per-port write data
- o_valid  out  1  head entry available
- i_ready  in  1  consumer accepts head
- o_entry  out  trace_entry_t  head entry: ts, port, reg, data
- o_count  out  $clog2(DEPTH)+1  entries held
- o_dropCnt  out  DROP_W  saturating count of lost entries
- o_overflow  out  1  sticky; set on the first loss

## Operation
- A port is accepted when i_enable && i_wrSig[p] && i_wrReg[p]!=0 && i_regMask[i_wrReg[p]]. Writes to x0 are never traced.
- Accepted ports enqueue in ascending port index in the same cycle. All entries from one cycle share one ts value.
- Timestamp counter: 0 after reset and increments every cycle. It wraps mod 2**TS_W and is not affected by i_clear.
- Pop occurs when o_valid && i_ready. FWFT: o_entry shows the head combinationally from storage.
- Free slots this cycle = DEPTH - o_count + pop. A same-cycle pop frees a slot for that cycle's pushes.
- Overflow with OVERWRITE=0: ports beyond free slots, highest index first, are discarded.
- Overflow with OVERWRITE=1: all accepted ports are written. The oldest entries after the popped one are evicted and the head advances by pop + evicted. o_count saturates at DEPTH.
- Each discarded or evicted entry increments o_dropCnt, which saturates at 2**DROP_W-1. o_overflow sets whenever o_dropCnt increments.
- i_clear takes priority over push and pop in that cycle. It empties the buffer and zeroes o_dropCnt and o_overflow. Writes in the clear cycle are lost and not counted.
- Pointers wrap mod DEPTH. Width rule: rd/wr pointers are $clog2(DEPTH) bits and the count is one bit wider.

## Timing
- Reset values: o_valid=0, o_count=0, o_dropCnt=0, o_overflow=0, o_entry=0, timestamp=0, pointers=0.
- Reset mid-operation discards all contents. There is no drain and no drop counting.
- Latency: a write accepted at edge N is visible at o_valid/o_entry after edge N, i.e. in cycle N+1.
- o_entry holds stable while o_valid && !i_ready.
- Empty with a push and i_ready in the same cycle: there is no bypass. The entry pops at the earliest in cycle N+1.
- Full with a pop and NUM_WR pushes in one cycle: 1 slot is free, so in drop mode NUM_WR-1 entries are lost.

## Structure
- Package id_trace_pkg: trace_entry_t packed struct {ts[TS_W], port[$clog2(NUM_WR)], reg[REG_AW], data[DATA_W]}, plus a helper function for accepted-port compaction. Struct widths come from package parameters that match the defaults. The top level asserts that its parameters agree.
- Sub-module id_trace_fifo: a multi-push (NUM_WR), single-pop circular buffer with the overflow policy and count. It reports the drop amount per cycle to the top, which owns filtering, the timestamp, and the drop counter.

## Test plan
- Reset, then port0 writes x5=0xDEADBEEF at ts=3 with mask all-ones: next cycle o_valid=1, o_entry={ts=3, port=0, reg=5, data=0xDEADBEEF}, o_count=1.
- Port0 writes x0 and port1 writes x7 while mask bit 7=0: no entries, o_count=0, o_dropCnt=0.
- Both ports write x1=0x11 and x2=0x22 in one cycle: two entries with equal ts, port0 first. Pop with i_ready=1 for 2 cycles and the buffer is empty.
- DEPTH=16, OVERWRITE=0, i_ready=0: 9 dual-write cycles give o_count=16, o_dropCnt=2, o_overflow=1, and the head is the first written entry.
- Same stimulus with OVERWRITE=1: o_count=16, o_dropCnt=2, and the head is the third written entry.
- Full buffer, i_clear together with pushes and a pop: next cycle o_count=0, o_valid=0, o_dropCnt=0, and the timestamp keeps counting. A mid-stream reset gives the same result with timestamp=0.
